// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: valid/ready byte in, serial frame out on RsTx at OVERSAMPLE clocks per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit(s).
module uart_transmitter #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                 uart_samplig_clk,
    input  logic                 reset,
    input  logic                 valid,
    output logic                 ready,
    input  logic [DATA_BITS-1:0] send_data,
    output logic                 RsTx,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CLK_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                 r_state,   w_state_nxt;
    logic [CW-1:0]          r_clk_cnt, w_clk_nxt;
    logic [BW-1:0]          r_bit_cnt, w_bit_nxt;
    logic [DATA_BITS-1:0]   r_shift,   w_shift_nxt;
    logic                   r_tx,      w_tx_nxt;
    logic                   w_wrap;
`ifdef UART_TX_PARITY_EN
    logic                   r_par,     w_par_nxt;
`endif

    assign w_wrap = (r_clk_cnt == CLK_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_clk_nxt   = r_clk_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
`ifdef UART_TX_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (valid) begin
                    w_shift_nxt = send_data;
                    w_clk_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = S_START;
`ifdef UART_TX_PARITY_EN
                    w_par_nxt   = ^send_data;
`endif
                end
            end
            S_START: begin
                if (w_wrap) begin
                    w_clk_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                    w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
                    w_state_nxt = S_DATA;
                end else begin
                    w_clk_nxt = r_clk_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_wrap) begin
                    w_clk_nxt = '0;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        w_tx_nxt    = r_par;
                        w_state_nxt = S_PARITY;
`else
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        // shift register already holds the next bit in position 0
                        w_tx_nxt    = r_shift[0];
                        w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
                        w_bit_nxt   = r_bit_cnt + 1'b1;
                    end
                end else begin
                    w_clk_nxt = r_clk_cnt + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_wrap) begin
                    w_clk_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = S_STOP;
                end else begin
                    w_clk_nxt = r_clk_cnt + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_wrap) begin
                    w_clk_nxt = '0;
                    // bit_cnt is reused to count stop bits
                    if (r_bit_cnt == STOP_LAST) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                end else begin
                    w_clk_nxt = r_clk_cnt + 1'b1;
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge uart_samplig_clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
`ifdef UART_TX_PARITY_EN
            r_par     <= w_par_nxt;
`endif
        end
    end

    assign ready = (r_state == S_IDLE);
    assign busy  = ~ready;
    assign RsTx  = r_tx;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: frame-position reference model checked every cycle, plus a
// mid-bit sampling receiver that decodes frames against literal bytes and timings.
module tb_uart_transmitter;

    localparam int OS = 16;
    localparam int DB = 8;
    localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PB        = 1;
    localparam int FRAME_LIT = 176;
`else
    localparam int PB        = 0;
    localparam int FRAME_LIT = 160;
`endif
    localparam int FL = (1 + DB + PB + SB) * OS;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid;
    logic [7:0] send_data;
    logic       ready;
    logic       RsTx;
    logic       busy;

    int checks;
    int errors;
    int cyc = 0;
    bit chk_en;
    int low_run;
    int last_low;

    // reference model: position within the current frame, advanced on every rising edge
    logic       m_active = 1'b0;
    int         m_pos    = 0;
    logic [7:0] m_byte   = 8'h00;

    uart_transmitter #(.OVERSAMPLE(OS), .DATA_BITS(DB), .STOP_BITS(SB)) dut (
        .uart_samplig_clk(clk),
        .reset           (reset),
        .valid           (valid),
        .ready           (ready),
        .send_data       (send_data),
        .RsTx            (RsTx),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (reset) begin
            m_active <= 1'b0;
            m_pos    <= 0;
        end else if (m_active) begin
            if (m_pos == FL - 1) m_active <= 1'b0;
            m_pos <= m_pos + 1;
        end else if (valid) begin
            m_active <= 1'b1;
            m_pos    <= 0;
            m_byte   <= send_data;
        end
    end

    function automatic logic exp_line(input int pos, input logic [7:0] b);
        int idx;
        idx = pos / OS;
        if (idx == 0) return 1'b0;
        if (idx <= DB) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == DB + 1) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        logic exp_tx;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_tx = m_active ? exp_line(m_pos, m_byte) : 1'b1;
                check("model_rstx",  {31'd0, RsTx},  {31'd0, exp_tx});
                check("model_ready", {31'd0, ready}, {31'd0, ~m_active});
                check("model_busy",  {31'd0, busy},  {31'd0, m_active});
                if (ready === 1'b0) low_run++;
                else if (low_run != 0) begin
                    last_low = low_run;
                    low_run  = 0;
                end
            end
        end
    endtask

    // present a byte, wait for the handshake edge; keep=1 leaves valid asserted afterwards
    task automatic send(input logic [7:0] b, input bit keep);
        bit done;
        done = 0;
        @(negedge clk);
        valid     = 1'b1;
        send_data = b;
        for (int i = 0; i < 2000; i++) begin
            if (ready === 1'b1) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        if (done) begin
            @(posedge clk);
            @(negedge clk);
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready=%0b expected 1 within 2000 cycles", ready);
        end
        if (!keep) valid = 1'b0;
    endtask

    task automatic rx(output logic [7:0] b, output logic par, output int t0, output bit ok);
        ok  = 0;
        b   = 8'h00;
        par = 1'b0;
        t0  = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (RsTx === 1'b0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL rx_timeout: got no start bit expected one within 3000 cycles");
            return;
        end
        t0 = cyc;
        repeat (OS / 2) @(negedge clk);
        check("rx_start_mid", {31'd0, RsTx}, 32'd0);
        for (int k = 0; k < DB; k++) begin
            repeat (OS) @(negedge clk);
            b[k] = RsTx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (OS) @(negedge clk);
        par = RsTx;
`endif
        repeat (OS) @(negedge clk);
        check("rx_stop_mid", {31'd0, RsTx}, 32'd1);
    endtask

    initial begin
        logic [7:0] b1, b2;
        logic       p1, p2;
        int         t1, t2;
        bit         ok1, ok2;

        reset = 1'b1; valid = 1'b0; send_data = 8'h00;
        chk_en = 0; checks = 0; errors = 0; low_run = 0; last_low = 0;
        fork monitor(); join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        check("reset_rstx",  {31'd0, RsTx},  32'd1);
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_busy",  {31'd0, busy},  32'd0);
        reset = 1'b0;

        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_rstx", {31'd0, RsTx}, 32'd1);
            check("idle_ready", {31'd0, ready}, 32'd1);
        end

        fork
            send(8'hA5, 0);
            rx(b1, p1, t1, ok1);
        join
        check("a5_byte", {24'd0, b1}, 32'h0000_00A5);
        repeat (40) @(negedge clk);
        check("a5_ready_low_len", last_low, FRAME_LIT);

        fork
            begin
                send(8'h00, 1);
                send(8'hFF, 0);
            end
            begin
                rx(b1, p1, t1, ok1);
                rx(b2, p2, t2, ok2);
            end
        join
        check("b2b_first",   {24'd0, b1}, 32'h0000_0000);
        check("b2b_second",  {24'd0, b2}, 32'h0000_00FF);
        check("b2b_spacing", t2 - t1, FRAME_LIT + 1);
        repeat (40) @(negedge clk);

        fork
            begin
                send(8'h55, 0);
                repeat (40) @(negedge clk);
                send_data = 8'hAA;
            end
            rx(b1, p1, t1, ok1);
        join
        check("latched_byte", {24'd0, b1}, 32'h0000_0055);
        repeat (40) @(negedge clk);

        send(8'h3C, 0);
        repeat (69) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_rstx",  {31'd0, RsTx},  32'd1);
        check("abort_ready", {31'd0, ready}, 32'd1);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_idle", {31'd0, RsTx}, 32'd1);
        fork
            send(8'h81, 0);
            rx(b1, p1, t1, ok1);
        join
        check("after_abort_byte", {24'd0, b1}, 32'h0000_0081);
        repeat (40) @(negedge clk);

`ifdef UART_TX_PARITY_EN
        fork
            send(8'h07, 0);
            rx(b1, p1, t1, ok1);
        join
        check("par07_byte", {24'd0, b1}, 32'h0000_0007);
        check("par07_bit",  {31'd0, p1}, 32'd1);
        repeat (40) @(negedge clk);
        check("par07_len", last_low, 176);
        fork
            send(8'h03, 0);
            rx(b2, p2, t2, ok2);
        join
        check("par03_byte", {24'd0, b2}, 32'h0000_0003);
        check("par03_bit",  {31'd0, p2}, 32'd0);
        repeat (40) @(negedge clk);
`endif

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
